// File: rtl/packet_sink.sv
// packet_sink: leaf-side receiver for the BFT network.
// It checks the destination of each packet and tracks a sequence number per source.
// Accepted {src,seq} pairs are queued in a show-ahead FIFO with a valid/ready output.
// The input is never stalled: a packet is sampled on every cycle.
module packet_sink #(
   parameter int num_leaves = 8,
   parameter int payload_sz = 7,
   parameter int addr       = 0,
   parameter int fifo_depth = 4,
   parameter int cnt_w      = 16,
   parameter int addr_w     = $clog2(num_leaves),
   parameter int seq_w      = payload_sz - addr_w,
   parameter int p_sz       = 1 + addr_w + payload_sz
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [p_sz-1:0]   bus_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [addr_w-1:0] out_src,
   output logic [seq_w-1:0]  out_seq,
   output logic [cnt_w-1:0]  rcvd_count,
   output logic [cnt_w-1:0]  err_seq_count,
   output logic [cnt_w-1:0]  drop_count,
   output logic              err_addr
);

   localparam int ptr_w = $clog2(fifo_depth);
   localparam logic [addr_w-1:0] my_addr = addr_w'(addr);

   // Packet field decode.
   logic              pkt_vld;
   logic [addr_w-1:0] pkt_dst;
   logic [addr_w-1:0] pkt_src;
   logic [seq_w-1:0]  pkt_seq;

   assign pkt_vld = bus_i[p_sz-1];
   assign pkt_dst = bus_i[p_sz-2 -: addr_w];
   assign pkt_src = bus_i[payload_sz-1 -: addr_w];
   assign pkt_seq = bus_i[seq_w-1:0];

   logic good, bad_dst;
   assign good    = pkt_vld && (pkt_dst == my_addr);
   assign bad_dst = pkt_vld && (pkt_dst != my_addr);

   // FIFO storage. Each pointer carries an extra wrap bit so that full and empty can be told apart.
   logic [fifo_depth-1:0][payload_sz-1:0] mem;
   logic [ptr_w:0] wr_ptr, rd_ptr;
   logic empty, full, pop, push, drop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ptr_w] != rd_ptr[ptr_w]) &&
                  (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]);
   assign pop   = !empty && out_ready;
   // A pop on the same edge frees the slot that a full FIFO needs.
   assign push  = good && (!full || pop);
   assign drop  = good && full && !pop;

   // The outputs come only from the registered pointers and storage.
   assign out_valid = !empty;
   assign {out_src, out_seq} = mem[rd_ptr[ptr_w-1:0]];

   // FIFO pointers and storage. The storage is cleared so that the head reads 0 after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[ptr_w-1:0]] <= {pkt_src, pkt_seq};
            wr_ptr <= wr_ptr + (ptr_w+1)'(1);
         end
         if (pop) rd_ptr <= rd_ptr + (ptr_w+1)'(1);
      end
   end

   // Per-source sequence tracker. It resynchronises to every good packet, including dropped ones.
   logic [num_leaves-1:0][seq_w-1:0] exp_seq;
   logic seq_err;
   assign seq_err = good && (pkt_seq != exp_seq[pkt_src]);

   // Per-source sequence tracker: after each good packet, expect the received sequence + 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) exp_seq <= '0;
      else if (good) exp_seq[pkt_src] <= pkt_seq + seq_w'(1);
   end

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcvd_count    <= '0;
         err_seq_count <= '0;
         drop_count    <= '0;
      end else begin
         if (push && rcvd_count != '1)       rcvd_count    <= rcvd_count + cnt_w'(1);
         if (seq_err && err_seq_count != '1) err_seq_count <= err_seq_count + cnt_w'(1);
         if (drop && drop_count != '1)       drop_count    <= drop_count + cnt_w'(1);
      end
   end

   // Sticky flag for a misrouted packet: it stays set until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_addr <= 1'b0;
      else if (bad_dst) err_addr <= 1'b1;
   end

endmodule

// File: tb/tb_packet_sink.sv
// Directed vector bench for packet_sink (addr=3, 8 leaves, seq_w=4, fifo_depth=4).
module tb_packet_sink;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] bus_i;
   logic        out_valid, out_ready;
   logic [2:0]  out_src;
   logic [3:0]  out_seq;
   logic [15:0] rcvd_count, err_seq_count, drop_count;
   logic        err_addr;

   packet_sink #(.num_leaves(8), .payload_sz(7), .addr(3), .fifo_depth(4), .cnt_w(16)) dut (
      .clk(clk), .reset(reset), .bus_i(bus_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_src(out_src), .out_seq(out_seq),
      .rcvd_count(rcvd_count), .err_seq_count(err_seq_count),
      .drop_count(drop_count), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] bus;
      logic        rdy;
      logic        ev;
      logic [2:0]  esrc;
      logic [3:0]  eseq;
      int          rc;
      int          ec;
      int          dc;
      logic        ea;
   } vec_t;

   vec_t vt[$];
   int n_chk = 0;
   int n_fail = 0;
   localparam logic [10:0] IDLE = 11'b0;

   function automatic logic [10:0] pk(int d, int s, int q);
      return {1'b1, 3'(d), 3'(s), 4'(q)};
   endfunction

   task automatic add(logic [10:0] b, logic r, logic ev, int es, int eq,
                      int rc, int ec, int dc, logic ea);
      vec_t v;
      v.bus = b; v.rdy = r; v.ev = ev; v.esrc = 3'(es); v.eseq = 4'(eq);
      v.rc = rc; v.ec = ec; v.dc = dc; v.ea = ea;
      vt.push_back(v);
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(logic [10:0] b, logic r);
      @(negedge clk);
      bus_i = b;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_vec(int idx, vec_t v);
      string t;
      t = $sformatf("vec%0d", idx);
      chk({t, ".valid"}, 32'(out_valid), 32'(v.ev));
      if (v.ev) begin
         chk({t, ".src"}, 32'(out_src), 32'(v.esrc));
         chk({t, ".seq"}, 32'(out_seq), 32'(v.eseq));
      end
      chk({t, ".rcvd"}, 32'(rcvd_count), 32'(v.rc));
      chk({t, ".err_seq"}, 32'(err_seq_count), 32'(v.ec));
      chk({t, ".drop"}, 32'(drop_count), 32'(v.dc));
      chk({t, ".err_addr"}, 32'(err_addr), 32'(v.ea));
   endtask

   initial begin
      reset = 1'b0;
      bus_i = IDLE;
      out_ready = 1'b0;
      #12;
      chk("rst.valid", 32'(out_valid), 0);
      chk("rst.src", 32'(out_src), 0);
      chk("rst.seq", 32'(out_seq), 0);
      chk("rst.rcvd", 32'(rcvd_count), 0);
      chk("rst.err_seq", 32'(err_seq_count), 0);
      chk("rst.drop", 32'(drop_count), 0);
      chk("rst.err_addr", 32'(err_addr), 0);
      @(negedge clk);
      reset = 1'b1;

      // The first good packet appears at the head one cycle later.
      add(pk(3,5,0), 0, 1, 5, 0, 1, 0, 0, 0);
      add(IDLE,      1, 0, 0, 0, 1, 0, 0, 0);
      // A sequence gap from src 5: 0 is followed by 2, where 1 was expected.
      add(pk(3,5,2), 0, 1, 5, 2, 2, 1, 0, 0);
      add(IDLE,      1, 0, 0, 0, 2, 1, 0, 0);
      // src 2 sends 0..15 and then 0. The wrap is in order. With ready held high, each packet becomes the head.
      for (int i = 0; i < 16; i++) add(pk(3,2,i), 1, 1, 2, i, 3+i, 1, 0, 0);
      add(pk(3,2,0), 1, 1, 2, 0, 19, 1, 0, 0);
      add(IDLE,      1, 0, 0, 0, 19, 1, 0, 0);
      // A wrong destination sets the sticky flag and otherwise has no effect.
      add(pk(4,1,3), 0, 0, 0, 0, 19, 1, 0, 1);
      for (int i = 0; i < 10; i++) add(IDLE, 0, 0, 0, 0, 19, 1, 0, 1);
      // Overflow: src 1 sends seq 0..4 while the consumer is stalled. Seq 0 must not raise an error.
      for (int i = 0; i < 4; i++) add(pk(3,1,i), 0, 1, 1, 0, 20+i, 1, 0, 1);
      add(pk(3,1,4), 0, 1, 1, 0, 23, 1, 1, 1);
      // Drain: the head advances 1, 2, 3, and then the FIFO is empty.
      add(IDLE, 1, 1, 1, 1, 23, 1, 1, 1);
      add(IDLE, 1, 1, 1, 2, 23, 1, 1, 1);
      add(IDLE, 1, 1, 1, 3, 23, 1, 1, 1);
      add(IDLE, 1, 0, 0, 0, 23, 1, 1, 1);
      // Refill to full with seq 5..8. The tracker continues after the dropped seq 4.
      for (int i = 0; i < 4; i++) add(pk(3,1,5+i), 0, 1, 1, 5, 24+i, 1, 1, 1);
      // Push while full with a pop on the same edge: no drop, and the head moves to 6.
      add(pk(3,1,9),  1, 1, 1, 6, 28, 1, 1, 1);
      // The FIFO still holds 4 entries, so the next packet without a pop is dropped.
      add(pk(3,1,10), 0, 1, 1, 6, 28, 1, 2, 1);
      // Second sequence error (src 6 expected 0). Push and pop again, then pop down to 3 entries.
      add(pk(3,6,5), 1, 1, 1, 7, 29, 2, 2, 1);
      add(IDLE,      1, 1, 1, 8, 29, 2, 2, 1);

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].bus, vt[i].rdy);
         chk_vec(i, vt[i]);
      end

      // Reset pulse between edges with 3 entries queued. It must take effect without a clock edge.
      @(negedge clk);
      bus_i = IDLE;
      out_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("mid_rst.valid", 32'(out_valid), 0);
      chk("mid_rst.rcvd", 32'(rcvd_count), 0);
      chk("mid_rst.err_seq", 32'(err_seq_count), 0);
      chk("mid_rst.drop", 32'(drop_count), 0);
      chk("mid_rst.err_addr", 32'(err_addr), 0);
      chk("mid_rst.src", 32'(out_src), 0);
      #1 reset = 1'b1;

      // Before the reset, src 5 expected 3 and src 1 expected 11. After it, seq 0 is in order for both.
      step(pk(3,5,0), 0);
      chk("post_rst.err_seq0", 32'(err_seq_count), 0);
      chk("post_rst.valid", 32'(out_valid), 1);
      chk("post_rst.src", 32'(out_src), 5);
      chk("post_rst.seq", 32'(out_seq), 0);
      chk("post_rst.rcvd0", 32'(rcvd_count), 1);
      step(pk(3,1,0), 0);
      chk("post_rst.err_seq1", 32'(err_seq_count), 0);
      chk("post_rst.rcvd1", 32'(rcvd_count), 2);
      chk("post_rst.head", 32'(out_src), 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/packet_sink.md
Name: packet_sink

Overview:
- Leaf-side receiver for the BFT network. It consumes packets that the network delivers to one PE on its interface_pe slice; it is the counterpart of packet_creator.
- Checks that each packet is addressed to this leaf and tracks a per-source sequence number to detect loss or reordering.
- Buffers accepted payloads in a small FIFO with a valid/ready output.
- The network gives no backpressure toward the leaf, so the block samples a packet every cycle and never stalls its input.

Parameters:
- num_leaves, 8, number of network leaves (power of 2, ≥2); addr_w = $clog2(num_leaves).
- payload_sz, 7, payload bits; must be ≥ addr_w+1. seq_w = payload_sz − addr_w.
- p_sz, 1+addr_w+payload_sz (11), packet width.
- addr, 0, this leaf's address (addr_w bits).
- fifo_depth, 4, output FIFO entries (power of 2, ≥2).
- cnt_w, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- bus_i  in  p_sz  packet from the network.
  - [p_sz−1] = valid
  - [p_sz−2 -: addr_w] = destination
  - [payload_sz−1 -: addr_w] = source
  - [seq_w−1:0] = sequence
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_src  out  addr_w  source of the head packet.
- out_seq  out  seq_w  sequence of the head packet.
- rcvd_count  out  cnt_w  packets accepted into the FIFO.
- err_seq_count  out  cnt_w  sequence mismatches.
- drop_count  out  cnt_w  packets dropped because the FIFO was full.
- err_addr  out  1  sticky; set when a packet arrives with the wrong destination.

Behaviour:
- Reset (reset==0, asynchronous):
  - FIFO is emptied; out_valid=0, out_src=0, out_seq=0.
  - All counters are 0; err_addr=0.
  - Every expected[s] is 0.
  - Takes effect immediately, mid-operation included; no partial state survives.
- A cycle with bus_i[p_sz−1]==0 is idle: no state changes apart from FIFO pops.
- Valid packet with destination ≠ addr:
  - err_addr<=1 and stays 1 until reset.
  - The packet is discarded: no FIFO push, no counter change, no change to expected[].
- Valid packet with destination == addr ("good"):
  - Sequence check: if seq ≠ expected[src], err_seq_count increments. In both cases expected[src]<=seq+1 mod 2^seq_w, so the tracker resynchronises to the received value.
  - Sequence wrap: 2^seq_w−1 followed by 0 is in order.
  - The check is performed whether or not the packet is then dropped.
  - Push {src,seq} into the FIFO and increment rcvd_count, unless the FIFO is full with no pop this cycle. In that case drop the packet and increment drop_count instead.
- FIFO:
  - Show-ahead: out_src/out_seq present the head whenever out_valid=1.
  - Pop when out_valid&&out_ready.
  - Simultaneous push and pop when full: both happen, no drop, count unchanged.
  - Simultaneous push and pop when empty: the push lands and the pop does not occur, since out_valid was 0.
  - Pointers are log2(fifo_depth) bits plus a wrap bit; full/empty are derived from them.
- Latency: a good packet sampled at edge N into an empty FIFO gives out_valid=1 with its fields during cycle N+1. Back-to-back packets are accepted every cycle.
- Counters saturate at 2^cnt_w−1; they never wrap.
- Outputs are driven from registers only; there is no combinational path from bus_i or out_ready to any output.

Test Plan (num_leaves=8, payload_sz=7, p_sz=11, addr=3, fifo_depth=4, seq_w=4):
- Single good packet: bus_i=11'b1_011_101_0000 for 1 cycle with out_ready=0 → next cycle out_valid=1, out_src=5, out_seq=0, rcvd_count=1, err_seq_count=0. Then out_ready=1 for 1 cycle → out_valid=0.
- Sequence gap then wrap:
  - From src 5, send seq 0 then seq 2 → err_seq_count=1, expected[5]=3.
  - From src 2, send seq 0..15 then 0 → err_seq_count stays 1.
- Wrong destination: bus_i=11'b1_100_001_0011 → err_addr=1 and remains 1 over 10 idle cycles; rcvd_count, FIFO and expected[1] unchanged.
- Overflow: out_ready=0 and 5 consecutive good packets (seq 0..4 from src 1).
  - Expect FIFO full, rcvd_count=4, drop_count=1.
  - Draining yields seq 0,1,2,3 in order.
  - Next, with the FIFO full, drive out_ready=1 alongside one good packet → drop_count stays 1, occupancy stays 4.
- Reset mid-operation: with 3 entries queued and err_seq_count=2, pulse reset low for half a cycle between edges → out_valid, counters and err_addr read 0 immediately. A packet with seq 0 from any source afterwards raises no sequence error.
